// File: rtl/ram_1p_pkg.sv
// Shared types and default sizing for the single-port RAM request controller.
package ram_1p_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_RSP_DEPTH  = 2;

endpackage

// File: rtl/ram_1p_rsp_fifo.sv
// Response FIFO for read data returning from the RAM macro; a circular buffer with an
// occupancy counter that also serves as the controller's credit source.
module ram_1p_rsp_fifo #(
  parameter int P_WIDTH = 32,
  parameter int P_DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic [P_WIDTH-1:0]             push_data_i,
  input  logic                           pop_i,
  output logic                           valid_o,
  output logic [P_WIDTH-1:0]             data_o,
  output logic [$clog2(P_DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(P_DEPTH + 1);
  localparam int PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               do_push, do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(P_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q < CW'(P_DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? nextPtr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? nextPtr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_1p_req_ctrl.sv
// Request controller in front of a single-port RAM macro: zero-fills the array after reset,
// then forwards requests and returns read data in order through a credit-limited FIFO.
module ram_1p_req_ctrl
  import ram_1p_pkg::*;
#(
  parameter int P_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int P_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int P_RSP_DEPTH  = DEF_RSP_DEPTH,
  parameter int P_INIT_EN    = 1
) (
  input  logic                    A_CLK,
  input  logic                    A_RST_N,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WE,
  input  logic [P_ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [P_DATA_WIDTH-1:0] REQ_WDATA,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [P_DATA_WIDTH-1:0] RSP_RDATA,
  output logic                    INIT_DONE,
  output logic                    M_MEN,
  output logic                    M_WEN,
  output logic                    M_REN,
  output logic [P_ADDR_WIDTH-1:0] M_ADDR,
  output logic [P_DATA_WIDTH-1:0] M_DIN,
  output logic                    M_DLY,
  input  logic [P_DATA_WIDTH-1:0] M_DOUT
);

  localparam int CW = $clog2(P_RSP_DEPTH + 1);
  localparam state_e RESET_STATE = (P_INIT_EN != 0) ? ST_INIT : ST_RUN;

  state_e                  state_q;
  logic [P_ADDR_WIDTH-1:0] init_cnt_q;
  logic                    inflight_q;
  logic                    init_done_q;
  logic [CW-1:0]           rsp_count;
  logic [CW:0]             credit_used;
  logic                    rsp_pop;
  logic                    read_ok;
  logic                    accept;

  assign rsp_pop = RSP_VALID && RSP_READY;

  // Credits count what will still occupy the FIFO after this cycle's pop, which lets a
  // depth-2 FIFO sustain one read per cycle while the consumer keeps up.
  assign credit_used = {1'b0, rsp_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, rsp_pop};
  assign read_ok     = credit_used < (CW + 1)'(P_RSP_DEPTH);

  assign REQ_READY = A_RST_N && (state_q == ST_RUN) && (REQ_WE || read_ok);
  assign accept    = REQ_VALID && REQ_READY;
  assign INIT_DONE = A_RST_N && init_done_q;
  assign M_DLY     = 1'b1;

  always_comb begin
    M_MEN  = 1'b0;
    M_WEN  = 1'b0;
    M_REN  = 1'b0;
    M_ADDR = '0;
    M_DIN  = '0;
    if (A_RST_N && (state_q == ST_INIT)) begin
      M_MEN  = 1'b1;
      M_WEN  = 1'b1;
      M_ADDR = init_cnt_q;
    end else if (accept) begin
      M_MEN  = 1'b1;
      M_WEN  = REQ_WE;
      M_REN  = !REQ_WE;
      M_ADDR = REQ_ADDR;
      M_DIN  = REQ_WDATA;
    end
  end

  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      state_q     <= RESET_STATE;
      init_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      init_done_q <= (RESET_STATE == ST_RUN);
    end else begin
      case (state_q)
        ST_INIT: begin
          inflight_q <= 1'b0;
          // The counter parks on the last address rather than wrapping.
          if (init_cnt_q == '1) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + P_ADDR_WIDTH'(1);
          end
        end
        default: begin
          inflight_q <= accept && !REQ_WE;
        end
      endcase
    end
  end

  ram_1p_rsp_fifo #(
    .P_WIDTH (P_DATA_WIDTH),
    .P_DEPTH (P_RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i       (A_CLK),
    .rst_ni      (A_RST_N),
    .push_i      (inflight_q),
    .push_data_i (M_DOUT),
    .pop_i       (rsp_pop),
    .valid_o     (RSP_VALID),
    .data_o      (RSP_RDATA),
    .count_o     (rsp_count)
  );

endmodule

// File: tb/tb_ram_1p_req_ctrl.sv
// Directed bench for ram_1p_req_ctrl with a behavioural RAM macro and a read-data scoreboard.
module tb_ram_1p_req_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          A_CLK;
  logic          A_RST_N;
  logic          REQ_VALID;
  logic          REQ_READY;
  logic          REQ_WE;
  logic [AW-1:0] REQ_ADDR;
  logic [DW-1:0] REQ_WDATA;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic [DW-1:0] RSP_RDATA;
  logic          INIT_DONE;
  logic          M_MEN;
  logic          M_WEN;
  logic          M_REN;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_DIN;
  logic          M_DLY;
  logic [DW-1:0] M_DOUT;

  logic [DW-1:0] macroMem [1 << AW];
  logic [DW-1:0] refMem   [1 << AW];
  logic [DW-1:0] expQ     [$];
  int            vectors;
  int            miscompares;
  logic          acc;

  ram_1p_req_ctrl #(
    .P_DATA_WIDTH (DW),
    .P_ADDR_WIDTH (AW),
    .P_RSP_DEPTH  (DEPTH),
    .P_INIT_EN    (1)
  ) dut (
    .A_CLK     (A_CLK),
    .A_RST_N   (A_RST_N),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WE    (REQ_WE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_RDATA (RSP_RDATA),
    .INIT_DONE (INIT_DONE),
    .M_MEN     (M_MEN),
    .M_WEN     (M_WEN),
    .M_REN     (M_REN),
    .M_ADDR    (M_ADDR),
    .M_DIN     (M_DIN),
    .M_DLY     (M_DLY),
    .M_DOUT    (M_DOUT)
  );

  initial begin
    A_CLK = 1'b0;
    forever #5 A_CLK = ~A_CLK;
  end

  // Behavioural macro: read data appears the cycle after the sampling edge.
  always @(posedge A_CLK) begin
    if (M_MEN) begin
      if (M_WEN) macroMem[M_ADDR] <= M_DIN;
      if (M_REN) M_DOUT <= macroMem[M_ADDR];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of request/response inputs, scores the handshakes, then advances a clock.
  task automatic applyStimulus(input logic v, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wd, input logic rr, output logic accepted);
    REQ_VALID = v;
    REQ_WE    = we;
    REQ_ADDR  = addr;
    REQ_WDATA = wd;
    RSP_READY = rr;
    #1;
    accepted = v && REQ_READY;
    if (accepted) begin
      checkOutput("m_men", {31'd0, M_MEN}, 32'd1);
      checkOutput("m_addr", {28'd0, M_ADDR}, {28'd0, addr});
      if (we) begin
        checkOutput("m_wen", {30'd0, M_WEN, M_REN}, 32'd2);
        checkOutput("m_din", M_DIN, wd);
        refMem[addr] = wd;
      end else begin
        checkOutput("m_ren", {30'd0, M_WEN, M_REN}, 32'd1);
        expQ.push_back(refMem[addr]);
      end
    end else begin
      checkOutput("m_men_idle", {29'd0, M_MEN, M_WEN, M_REN}, 32'd0);
    end
    if (RSP_VALID && RSP_READY) begin
      if (expQ.size() == 0) checkOutput("rsp_unexpected", {31'd0, RSP_VALID}, 32'd0);
      else checkOutput("rsp_data", RSP_RDATA, expQ.pop_front());
    end
    @(posedge A_CLK);
    #1;
  endtask

  task automatic runInit(input int n);
    for (int k = 0; k < n; k++) begin
      REQ_VALID = 1'b1;
      REQ_WE    = 1'b1;
      REQ_ADDR  = AW'(k);
      #1;
      checkOutput("init_addr", {28'd0, M_ADDR}, 32'(k));
      checkOutput("init_en", {29'd0, M_MEN, M_WEN, M_REN}, 32'd6);
      checkOutput("init_din", M_DIN, 32'd0);
      checkOutput("init_ready", {30'd0, REQ_READY, INIT_DONE}, 32'd0);
      @(posedge A_CLK);
      #1;
    end
    REQ_VALID = 1'b0;
    for (int k = 0; k < (1 << AW); k++) refMem[k] = '0;
  endtask

  task automatic drain(input int maxCycles);
    logic a;
    for (int k = 0; k < maxCycles && expQ.size() > 0; k++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, a);
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
    checkOutput("drain_valid", {31'd0, RSP_VALID}, 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput(tag, {25'd0, REQ_READY, RSP_VALID, INIT_DONE, M_MEN, M_WEN, M_REN, M_DLY}, 32'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    A_RST_N     = 1'b0;
    REQ_VALID   = 1'b0;
    REQ_WE      = 1'b0;
    REQ_ADDR    = '0;
    REQ_WDATA   = '0;
    RSP_READY   = 1'b0;
    M_DOUT      = '0;
    for (int k = 0; k < (1 << AW); k++) macroMem[k] = 32'hA5A5_0000 | 32'(k);

    // Reset values, then a full zero-fill sweep.
    @(posedge A_CLK);
    #1;
    checkResetOutputs("reset_outputs");
    A_RST_N = 1'b1;
    runInit(1 << AW);
    checkOutput("init_done", {31'd0, INIT_DONE}, 32'd1);
    checkOutput("idle_rsp", {31'd0, RSP_VALID}, 32'd0);

    // Write then read back with exact one-cycle latency.
    applyStimulus(1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b1, acc);
    checkOutput("wr_accept", {31'd0, acc}, 32'd1);
    applyStimulus(1'b1, 1'b0, 4'd5, '0, 1'b1, acc);
    checkOutput("rd_accept", {31'd0, acc}, 32'd1);
    checkOutput("rd_lat_pre", {31'd0, RSP_VALID}, 32'd0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, acc);
    checkOutput("rd_lat_valid", {31'd0, RSP_VALID}, 32'd1);
    drain(4);

    // Unwritten address reads back as zero.
    applyStimulus(1'b1, 1'b0, 4'd9, '0, 1'b1, acc);
    drain(4);

    // Back-pressure: only two reads fit, writes still pass, data held then returned in order.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, (k == 1) ? 4'd9 : 4'd5, '0, 1'b0, acc);
      checkOutput("bp_read_accept", {31'd0, acc}, (k < 2) ? 32'd1 : 32'd0);
    end
    checkOutput("bp_hold0", RSP_RDATA, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b1, 4'd3, 32'h0000_1234, 1'b0, acc);
    checkOutput("bp_write_accept", {31'd0, acc}, 32'd1);
    checkOutput("bp_hold1", RSP_RDATA, 32'hDEAD_BEEF);
    drain(6);

    // Streaming reads with no bubbles.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b1, AW'(k + 8), 32'h1000_0000 + 32'(k) * 32'h0101, 1'b1, acc);
      checkOutput("stream_wr_accept", {31'd0, acc}, 32'd1);
    end
    for (int k = 0; k < 8; k++) begin
      if (k >= 2) checkOutput("stream_valid", {31'd0, RSP_VALID}, 32'd1);
      applyStimulus(1'b1, 1'b0, AW'(k + 8), '0, 1'b1, acc);
      checkOutput("stream_rd_accept", {31'd0, acc}, 32'd1);
    end
    checkOutput("stream_tail_valid", {31'd0, RSP_VALID}, 32'd1);
    drain(6);

    // Reset with two responses queued discards them.
    applyStimulus(1'b1, 1'b0, 4'd5, '0, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 4'd3, '0, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, acc);
    checkOutput("queued_valid", {31'd0, RSP_VALID}, 32'd1);
    A_RST_N = 1'b0;
    #1;
    checkResetOutputs("reset_queued");
    expQ.delete();
    @(posedge A_CLK);
    #1;

    // Reset mid-sweep restarts the zero-fill from address 0.
    A_RST_N = 1'b1;
    runInit(7);
    A_RST_N = 1'b0;
    #1;
    checkResetOutputs("reset_mid_init");
    @(posedge A_CLK);
    #1;
    A_RST_N = 1'b1;
    runInit(1 << AW);
    checkOutput("reinit_done", {31'd0, INIT_DONE}, 32'd1);
    checkOutput("no_stale_rsp", {31'd0, RSP_VALID}, 32'd0);
    applyStimulus(1'b1, 1'b0, 4'd5, '0, 1'b1, acc);
    checkOutput("post_reset_rd_accept", {31'd0, acc}, 32'd1);
    drain(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_1p_req_ctrl.md
RAM_1P_REQ_CTRL -- requirements
Module: ram_1p_req_ctrl

Interface
REQ-001 Parameters SHALL be: P_DATA_WIDTH, default 32, data word width; P_ADDR_WIDTH, default 13, word address width; P_RSP_DEPTH, default 2, response FIFO entries (>=2); P_INIT_EN, default 1, zero-fill memory after reset.
REQ-002 A_CLK  in  1  single clock; all flops are posedge A_CLK.
REQ-003 A_RST_N  in  1  reset, asynchronous assert, active-low.
REQ-004 REQ_VALID  in  1  request present.
REQ-005 REQ_READY  out  1  request accepted this cycle when REQ_VALID is also high.
REQ-006 REQ_WE  in  1  1=write, 0=read.
REQ-007 REQ_ADDR  in  P_ADDR_WIDTH  word address.
REQ-008 REQ_WDATA  in  P_DATA_WIDTH  write data.
REQ-009 RSP_VALID  out  1  read data available.
REQ-010 RSP_READY  in  1  consumer takes RSP_RDATA.
REQ-011 RSP_RDATA  out  P_DATA_WIDTH  read data, in request order.
REQ-012 INIT_DONE  out  1  zero-fill complete; requests are now serviced.
REQ-013 M_MEN, M_WEN, M_REN  out  1 each  macro enables.
REQ-014 M_ADDR  out  P_ADDR_WIDTH  macro address.
REQ-015 M_DIN  out  P_DATA_WIDTH  macro write data.
REQ-016 M_DLY  out  1  macro delay select; tied 1.
REQ-017 M_DOUT  in  P_DATA_WIDTH  macro read data, valid the cycle after the sampling edge.

Function
REQ-018 The FSM SHALL have states INIT and RUN; after reset it enters INIT when P_INIT_EN=1, otherwise RUN.
REQ-019 In INIT, each cycle it SHALL drive M_MEN=1, M_WEN=1, M_REN=0, M_DIN=0, M_ADDR=init counter; the counter starts at 0 and increments by 1.
REQ-020 The INIT->RUN transition SHALL occur on the edge that writes address 2^P_ADDR_WIDTH-1; the counter SHALL NOT wrap.
REQ-021 INIT_DONE SHALL be 1 exactly in RUN, and REQ_READY SHALL be 0 in INIT.
REQ-022 In RUN, a request SHALL be accepted on an edge where REQ_VALID&&REQ_READY; macro signals are combinational from the request: M_MEN=REQ_VALID&&REQ_READY, M_WEN=M_MEN&&REQ_WE, M_REN=M_MEN&&!REQ_WE, M_ADDR=REQ_ADDR, M_DIN=REQ_WDATA.
REQ-023 When no request is accepted, M_MEN/M_WEN/M_REN SHALL be 0; M_ADDR/M_DIN are don't-care but SHALL be X-free.
REQ-024 Writes SHALL need no response; in RUN, REQ_READY SHALL be 1 for writes unconditionally.
REQ-025 For reads, REQ_READY SHALL be 1 only if (FIFO occupancy + in-flight read) < P_RSP_DEPTH, where in-flight is 1 for a read accepted on the previous edge.
REQ-026 A read accepted at edge T SHALL push M_DOUT into the response FIFO at edge T+1, so RSP_VALID is visible from T+1 with an empty FIFO (latency 1).
REQ-027 The FIFO SHALL pop on RSP_VALID&&RSP_READY; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-028 RSP_RDATA SHALL hold stable while RSP_VALID&&!RSP_READY.
REQ-029 Back-to-back reads SHALL sustain one per cycle while RSP_READY=1 and P_RSP_DEPTH>=2.
REQ-030 Occupancy SHALL never exceed P_RSP_DEPTH, and the FIFO SHALL never overflow or underflow.

Reset
REQ-031 Asserting A_RST_N low at any time, including mid-INIT or with reads in flight, SHALL asynchronously clear the FSM to its post-reset state, the init counter to 0, FIFO occupancy to 0, and in-flight to 0.
REQ-032 During reset, outputs SHALL be: REQ_READY=0, RSP_VALID=0, INIT_DONE=0, M_MEN=M_WEN=M_REN=0, M_DLY=1.
REQ-033 Reads that are pending when reset asserts SHALL be discarded without a response.

Structure
REQ-034 The FSM state enum and the default widths/depth SHALL live in shared package ram_1p_pkg.
REQ-035 The response FIFO SHALL be the single sub-module ram_1p_rsp_fifo, parameterised by width and depth.
REQ-036 Macro instantiation SHALL stay outside this block.

Verification
REQ-037 Reset release, P_ADDR_WIDTH=4 -> 16 zero writes to addresses 0..15 on consecutive cycles; INIT_DONE rises the cycle after address 15 is written.
REQ-038 Write 0xDEADBEEF to address 5, then read address 5 -> RSP_VALID on the edge after read acceptance with RSP_RDATA=0xDEADBEEF.
REQ-039 RSP_READY=0 with 4 reads requested, depth 2 -> exactly 2 accepted and REQ_READY=0 for reads; writes are still accepted; releasing RSP_READY returns data in order.
REQ-040 Streaming reads with RSP_READY=1 -> one accept and one response per cycle, with no bubbles.
REQ-041 Reset asserted mid-INIT (counter=7) and with 2 responses queued -> all outputs take reset values immediately; INIT restarts at address 0; no stale RSP_VALID.
REQ-042 Read of an unwritten address after INIT -> RSP_RDATA=0.
